input_conditioner: RTL and testbench

- Front-end stage that feeds the main control FSM.
- Takes the raw, asynchronous panel switches/buttons (ME[1:0], SSP[1:0], PF[1:0], EL, LP) and synchronizes and debounces each bit.
- Presents clean levels plus one-cycle rise/fall pulses, so the FSM's next-state logic only ever sees stable, clock-aligned inputs.
- A `ready` flag tells downstream logic when the input levels are trustworthy after reset.

---
 rtl/input_conditioner_pkg.sv | 26 ++
 rtl/input_conditioner_debounce_ch.sv | 55 +++++
 rtl/input_conditioner.sv | 76 +++++++
 tb/tb_input_conditioner.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the panel input conditioner: bit map of the
// conditioned input vector, default debounce length and startup states.
package input_conditioner_pkg;

  // Bit positions inside raw_in / level_out
  localparam int IDX_EL  = 0;
  localparam int IDX_LP  = 1;
  localparam int IDX_PF  = 2;
  localparam int IDX_SSP = 4;
  localparam int IDX_ME  = 6;

  // Field widths of the multi-bit switches
  localparam int PF_W  = 2;
  localparam int SSP_W = 2;
  localparam int ME_W  = 2;

  // 10 ms at 50 MHz
  localparam int DB_CYCLES_DEFAULT = 500000;

  // Startup settle FSM encoding
  typedef enum logic {
    WAIT = 1'b0,
    RUN  = 1'b1
  } startup_state_t;

endpackage

// File: rtl/input_conditioner_debounce_ch.sv
// One conditioned input bit: two-flop synchronizer, hold counter,
// debounced level and registered rise/fall pulses.
module debounce_ch
  import input_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic pulse_en,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count how long the new level has held, accept it after
  // DB_CYCLES consecutive cycles and emit a one-cycle pulse on acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      // stage 0 -> 1: metastability guard
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      // stage 1 -> level: any cycle that agrees with the current level
      // restarts the hold count, so bounces never accumulate
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        rise  <= pulse_en & sync_p1;
        fall  <= pulse_en & ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Panel input conditioner: per-bit synchronize/debounce channels plus a
// startup settle window that qualifies the levels and suppresses the
// edge pulses until the inputs have had time to settle after reset.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             ready
);

  // Settle window spans DB_CYCLES+2 edges: two synchronizer flops plus
  // a full debounce hold.
  localparam int             SU_W    = $clog2(DB_CYCLES + 2) + 1;
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(DB_CYCLES + 1);

  startup_state_t  state;
  logic [SU_W-1:0] su_cnt;
  logic            pulse_en;

  // Startup FSM: count the settle window once after reset, then stay in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= WAIT;
      su_cnt <= '0;
      ready  <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (su_cnt == SU_LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            su_cnt <= su_cnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
          ready <= 1'b1;
        end
        default: begin
          state <= WAIT;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Pulses are qualified by the state before the edge, so an input that
  // is already active at power-up is accepted silently during WAIT.
  assign pulse_en = (state == RUN);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES (DB_CYCLES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_in[i]),
      .pulse_en (pulse_en),
      .level    (level_out[i]),
      .rise     (rise_out[i]),
      .fall     (fall_out[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DB_CYCLES=4: settle after reset,
// table of level transitions in RUN, bounce rejection and reset mid-count.
module tb_input_conditioner;

  localparam int W  = 8;
  localparam int DB = 4;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level_out;
  logic [W-1:0] rise_out;
  logic [W-1:0] fall_out;
  logic         ready;

  int n_vec = 0;
  int n_bad = 0;

  vec_t vecs [9];
  vec_t exp_q [$];

  input_conditioner #(
    .WIDTH     (W),
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_out  (rise_out),
    .fall_out  (fall_out),
    .ready     (ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] lvl, input logic [7:0] r,
                         input logic [7:0] f, input logic rdy);
    chk({tag, ".level"}, level_out, lvl);
    chk({tag, ".rise"}, rise_out, r);
    chk({tag, ".fall"}, fall_out, f);
    chk({tag, ".ready"}, {7'b0, ready}, {7'b0, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t       e;
    logic [7:0] prev;
    logic       bounce [14];

    vecs[0] = '{8'h00, 8'h00, 8'h00, 8'hFF};
    vecs[1] = '{8'h01, 8'h01, 8'h01, 8'h00};
    vecs[2] = '{8'hC1, 8'hC1, 8'hC0, 8'h00};
    vecs[3] = '{8'h01, 8'h01, 8'h00, 8'hC0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 8'h01};
    vecs[5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
    vecs[6] = '{8'hA5, 8'hA5, 8'h00, 8'h5A};
    vecs[7] = '{8'h5A, 8'h5A, 8'h5A, 8'hA5};
    vecs[8] = '{8'h00, 8'h00, 8'h00, 8'h5A};

    bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset held with all switches on: everything reads 0
    reset  = 1'b0;
    raw_in = 8'hFF;
    repeat (3) step();
    chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 1'b0);

    // Release: level and ready appear together on edge 6, no rise pulse
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("settle_e%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    chk_all("settle_e6", 8'hFF, 8'h00, 8'h00, 1'b1);
    step();
    chk_all("settle_e7", 8'hFF, 8'h00, 8'h00, 1'b1);

    // Table of clean transitions in RUN
    prev = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      raw_in = vecs[i].raw;
      exp_q.push_back(vecs[i]);
      for (int k = 1; k <= 5; k++) begin
        step();
        chk_all($sformatf("vec%0d_e%0d", i, k), prev, 8'h00, 8'h00, 1'b1);
      end
      step();
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL vec%0d_queue: got empty scoreboard, expected one entry", i);
      end else begin
        e = exp_q.pop_front();
        chk_all($sformatf("vec%0d_e6", i), e.lvl, e.rise, e.fall, 1'b1);
        step();
        chk_all($sformatf("vec%0d_e7", i), e.lvl, 8'h00, 8'h00, 1'b1);
        prev = e.lvl;
      end
    end

    // Bounce on LP: 3 high, 1 low, 3 high, then low -> never accepted
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      raw_in = {6'b0, bounce[k], 1'b0};
      step();
      chk_all($sformatf("bounce_c%0d", k), 8'h00, 8'h00, 8'h00, 1'b1);
    end

    // Reset asserted while PF[0] is mid-count (counter at 2 after edge 4)
    @(negedge clk);
    raw_in = 8'h04;
    repeat (4) step();
    reset = 1'b0;
    #1;
    chk_all("midrst_now", 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) step();
    chk_all("midrst_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all($sformatf("midrst_e%0d", k), 8'h00, 8'h00, 8'h00, 1'b0);
    end
    step();
    chk_all("midrst_e6", 8'h04, 8'h00, 8'h00, 1'b1);
    step();
    chk_all("midrst_e7", 8'h04, 8'h00, 8'h00, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
